// File: rtl/psum_axis_packer.sv
// psum_axis_packer: 2-deep psum vector FIFO drained as an AXI-Stream word sequence.
// Define PSUM_PACKER_DROP_CNT_EN to build the saturating dropped-vector counter.
module psum_axis_packer #(
  parameter int MAC_NUM              = 256,
  parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [5*MAC_NUM-1:0]                psum_out,
  input  logic                                psum_valid,
  input  logic [15:0]                         vectors_per_frame,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,
  output logic                                overflow,
  output logic                                frame_done,
  output logic                                busy,
  output logic [15:0]                         drop_count
);

  localparam int DW = C_M_AXIS_TDATA_WIDTH;
  localparam int W  = 5 * MAC_NUM / DW;
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST_W = IW'(W - 1);

  typedef enum logic {IDLE, SEND} state_t;
  typedef logic [W-1:0][DW-1:0] vec_t;

  vec_t          mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;
  logic [1:0]    count_nxt;
  state_t        state_q;
  logic [IW-1:0] word_q;
  logic [15:0]   vec_cnt_q;
  logic [15:0]   frame_len_q;
  logic [15:0]   len_in;
  logic [15:0]   frame_len;
  logic          last_vec;
  logic          hs;
  logic          last_hs;
  logic          push;
  logic          drop;

  // First word of a frame uses the live length; later words use the latched one
  assign len_in    = (vectors_per_frame == 16'd0) ? 16'd1 : vectors_per_frame;
  assign frame_len = (vec_cnt_q == 16'd0 && word_q == '0) ? len_in : frame_len_q;
  assign last_vec  = (vec_cnt_q == frame_len - 16'd1);

  assign M_AXIS_TVALID = (state_q == SEND);
  assign hs            = M_AXIS_TVALID & M_AXIS_TREADY;
  assign last_hs       = hs & (word_q == LAST_W);

  // A full FIFO still accepts when the head vector retires this cycle
  assign push      = psum_valid & ((count_q != 2'd2) | last_hs);
  assign drop      = psum_valid & ~push;
  assign count_nxt = count_q + {1'b0, push} - {1'b0, last_hs};

  assign M_AXIS_TDATA = M_AXIS_TVALID ? mem_q[rd_ptr_q][word_q] : '0;
  assign M_AXIS_TLAST = M_AXIS_TVALID & (word_q == LAST_W) & last_vec;
  assign M_AXIS_TSTRB = '1;
  assign busy         = (count_q != 2'd0);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= psum_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      word_q      <= '0;
      vec_cnt_q   <= '0;
      frame_len_q <= '0;
      overflow    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      count_q    <= count_nxt;
      overflow   <= overflow | drop;
      frame_done <= last_hs & last_vec;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (last_hs) rd_ptr_q <= ~rd_ptr_q;
      if (hs) word_q <= last_hs ? '0 : word_q + 1'b1;
      if (hs && word_q == '0 && vec_cnt_q == 16'd0)
        frame_len_q <= len_in;
      if (last_hs)
        vec_cnt_q <= last_vec ? 16'd0 : vec_cnt_q + 16'd1;
      unique case (state_q)
        IDLE: if (count_nxt != 2'd0) state_q <= SEND;
        SEND: if (last_hs && count_nxt == 2'd0) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PSUM_PACKER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 16'hFFFF)
      drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_psum_axis_packer.sv
// Bench for psum_axis_packer: queue-based scoreboard, directed table, corner sequences.
// Expected drop_count follows PSUM_PACKER_DROP_CNT_EN.
module tb_psum_axis_packer;

  localparam int MAC_NUM = 256;
  localparam int DW      = 32;
  localparam int VW      = 5 * MAC_NUM;
  localparam int W       = VW / DW;
`ifdef PSUM_PACKER_DROP_CNT_EN
  localparam logic [15:0] EXP_DC = 16'd1;
`else
  localparam logic [15:0] EXP_DC = 16'd0;
`endif

  typedef logic [VW-1:0] vec_t;

  typedef struct {
    logic [15:0] vpf;
    int          nvec;
    int          spacing;
    bit          toggle;
    int          e_words;
    int          e_tlast;
    int          e_fd;
    int          e_valid;
  } tv_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [VW-1:0]     psum_out;
  logic              psum_valid;
  logic [15:0]       vpf;
  logic              tvalid;
  logic [DW-1:0]     tdata;
  logic [DW/8-1:0]   tstrb;
  logic              tlast;
  logic              tready;
  logic              overflow;
  logic              frame_done;
  logic              busy;
  logic [15:0]       drop_count;

  always #5 clk = ~clk;

  psum_axis_packer #(
    .MAC_NUM              (MAC_NUM),
    .C_M_AXIS_TDATA_WIDTH (DW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .psum_out          (psum_out),
    .psum_valid        (psum_valid),
    .vectors_per_frame (vpf),
    .M_AXIS_TVALID     (tvalid),
    .M_AXIS_TDATA      (tdata),
    .M_AXIS_TSTRB      (tstrb),
    .M_AXIS_TLAST      (tlast),
    .M_AXIS_TREADY     (tready),
    .overflow          (overflow),
    .frame_done        (frame_done),
    .busy              (busy),
    .drop_count        (drop_count)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference: queue of buffered vectors, word position, frame position
  vec_t        mq[$];
  int          mw;
  int          vif;
  int          flen;
  bit          flen_ok;
  bit          etl_q;
  bit          fd_exp;
  bit          ovf_exp;
  bit          in_rst;
  logic [15:0] dc_exp;

  int nwords;
  int ntlast;
  int nfd;
  int nvalid;

  tv_t tab[5];

  task automatic cmp(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                 nm, act, exp, $time);
    end
  endtask

  function automatic vec_t rvec();
    vec_t v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic clr();
    nwords = 0;
    ntlast = 0;
    nfd    = 0;
    nvalid = 0;
  endtask

  task automatic model_clear();
    mq.delete();
    mw      = 0;
    vif     = 0;
    flen    = 1;
    flen_ok = 1'b0;
    etl_q   = 1'b0;
    fd_exp  = 1'b0;
    ovf_exp = 1'b0;
    dc_exp  = 16'd0;
  endtask

  // Compare DUT outputs to the model; called on the falling edge
  task automatic check();
    logic          etv;
    logic          etl;
    logic [DW-1:0] etd;
    vec_t          hv;
    etv = (mq.size() != 0);
    etd = '0;
    if (etv && mw == 0 && vif == 0 && !flen_ok) begin
      flen    = (vpf == 16'd0) ? 1 : int'(vpf);
      flen_ok = 1'b1;
    end
    etl = etv && (mw == W - 1) && (vif == flen - 1);
    if (etv) begin
      hv  = mq[0];
      etd = hv[mw*DW +: DW];
    end
    cmp("tvalid", 64'(tvalid), 64'(etv));
    cmp("tlast", 64'(tlast), 64'(etl));
    if (etv) begin
      cmp("tdata", 64'(tdata), 64'(etd));
      cmp("tstrb", 64'(tstrb), 64'(4'hF));
    end
    if (in_rst) cmp("rst_tdata", 64'(tdata), 64'd0);
    cmp("frame_done", 64'(frame_done), 64'(fd_exp));
    cmp("overflow", 64'(overflow), 64'(ovf_exp));
    cmp("drop_count", 64'(drop_count), 64'(dc_exp));
    cmp("busy", 64'(busy), 64'(etv));
    if (tvalid === 1'b1) nvalid++;
    if (frame_done === 1'b1) nfd++;
    etl_q = etl;
  endtask

  // Drive inputs for the next rising edge and advance the model across it
  task automatic drive(input logic pv, input logic rdy, input logic r);
    vec_t v;
    int   sz;
    bit   hs;
    bit   lhs;
    v          = rvec();
    psum_valid = pv;
    psum_out   = v;
    tready     = rdy;
    rst        = r;
    if (tvalid === 1'b1 && rdy) begin
      nwords++;
      if (tlast === 1'b1) ntlast++;
    end
    if (r) begin
      model_clear();
      in_rst = 1'b1;
    end else begin
      in_rst = 1'b0;
      sz     = mq.size();
      hs     = (sz != 0) && rdy;
      lhs    = hs && (mw == W - 1);
      fd_exp = hs && etl_q;
      if (hs) begin
        if (lhs) begin
          mq.delete(0);
          mw = 0;
          if (etl_q) begin
            vif     = 0;
            flen_ok = 1'b0;
          end else begin
            vif++;
          end
        end else begin
          mw++;
        end
      end
      if (pv) begin
        if (sz < 2 || (sz == 2 && lhs)) begin
          mq.push_back(v);
        end else begin
          ovf_exp = 1'b1;
`ifdef PSUM_PACKER_DROP_CNT_EN
          if (dc_exp != 16'hFFFF) dc_exp = dc_exp + 16'd1;
`endif
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc(input logic pv, input logic rdy, input logic r);
    check();
    drive(pv, rdy, r);
  endtask

  task automatic rst_seq();
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (mq.size() != 0 && k < budget) begin
      cyc(1'b0, 1'b1, 1'b0);
      k++;
    end
    if (mq.size() != 0) cmp("drain_timeout", 64'd0, 64'd1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int  pushed;
    bit  done;
    bit  fired;
    int  k;
    logic pv;
    logic rdy;
    logic r;

    tab[0] = '{16'd1, 1, 1,  1'b0, 40,  1, 1, 40};
    tab[1] = '{16'd3, 3, 50, 1'b0, 120, 1, 1, 120};
    tab[2] = '{16'd1, 1, 1,  1'b1, 40,  1, 1, 80};
    tab[3] = '{16'd0, 2, 1,  1'b0, 80,  2, 2, 80};
    tab[4] = '{16'd2, 3, 50, 1'b0, 120, 1, 1, 120};

    psum_valid = 1'b0;
    psum_out   = '0;
    tready     = 1'b0;
    vpf        = 16'd1;
    rst        = 1'b1;
    in_rst     = 1'b0;
    model_clear();
    clr();
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);

    cmp("reset_tvalid", 64'(tvalid), 64'd0);
    cmp("reset_tlast", 64'(tlast), 64'd0);
    cmp("reset_tdata", 64'(tdata), 64'd0);
    cmp("reset_overflow", 64'(overflow), 64'd0);
    cmp("reset_busy", 64'(busy), 64'd0);
    cmp("reset_drop_count", 64'(drop_count), 64'd0);

    for (int t = 0; t < 5; t++) begin
      vpf = tab[t].vpf;
      rst_seq();
      clr();
      pushed = 0;
      done   = 1'b0;
      for (int c = 0; c < 800 && !done; c++) begin
        check();
        pv = (pushed < tab[t].nvec) && (c % tab[t].spacing == 0);
        if (pv) pushed++;
        rdy = tab[t].toggle ? (nvalid % 2 == 0) : 1'b1;
        drive(pv, rdy, 1'b0);
        done = (pushed == tab[t].nvec) && (mq.size() == 0);
      end
      if (!done) cmp("tab_timeout", 64'd0, 64'd1);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cmp($sformatf("tab%0d_words", t), 64'(nwords), 64'(tab[t].e_words));
      cmp($sformatf("tab%0d_tlast", t), 64'(ntlast), 64'(tab[t].e_tlast));
      cmp($sformatf("tab%0d_fdone", t), 64'(nfd), 64'(tab[t].e_fd));
      cmp($sformatf("tab%0d_valid", t), 64'(nvalid), 64'(tab[t].e_valid));
    end

    // Three back-to-back vectors into a stalled sink
    vpf = 16'd1;
    rst_seq();
    clr();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    cmp("burst_overflow", 64'(overflow), 64'd1);
    cmp("burst_drop_count", 64'(drop_count), 64'(EXP_DC));
    clr();
    drain(400);
    cmp("burst_words", 64'(nwords), 64'd80);
    cmp("burst_valid", 64'(nvalid), 64'd80);
    cmp("burst_tlast", 64'(ntlast), 64'd2);
    cmp("burst_sticky", 64'(overflow), 64'd1);

    // Push while full, coinciding with the head's last-word handshake
    rst_seq();
    clr();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    fired = 1'b0;
    k     = 0;
    while (mq.size() != 0 && k < 400) begin
      check();
      if (!fired && nwords == 39) begin
        fired = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
      end else begin
        drive(1'b0, 1'b1, 1'b0);
      end
      k++;
    end
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cmp("coincide_fired", 64'(fired), 64'd1);
    cmp("coincide_overflow", 64'(overflow), 64'd0);
    cmp("coincide_words", 64'(nwords), 64'd120);
    cmp("coincide_tlast", 64'(ntlast), 64'd3);

    // Reset in the middle of a packet
    rst_seq();
    clr();
    cyc(1'b1, 1'b1, 1'b0);
    k = 0;
    while (nwords < 17 && k < 100) begin
      cyc(1'b0, 1'b1, 1'b0);
      k++;
    end
    cyc(1'b0, 1'b1, 1'b1);
    cmp("midrst_tvalid", 64'(tvalid), 64'd0);
    cmp("midrst_tlast", 64'(tlast), 64'd0);
    cmp("midrst_tdata", 64'(tdata), 64'd0);
    cmp("midrst_busy", 64'(busy), 64'd0);
    cmp("midrst_fdone", 64'(frame_done), 64'd0);
    cyc(1'b0, 1'b1, 1'b0);
    clr();
    cyc(1'b1, 1'b1, 1'b0);
    drain(200);
    cmp("midrst_words", 64'(nwords), 64'd40);
    cmp("midrst_tlast_cnt", 64'(ntlast), 64'd1);
    cmp("midrst_fd_cnt", 64'(nfd), 64'd1);

    // Random traffic against the scoreboard
    rst_seq();
    for (int c = 0; c < 3000; c++) begin
      check();
      if (mq.size() == 0 && $urandom_range(0, 3) == 0)
        vpf = 16'($urandom_range(0, 3));
      pv  = ($urandom_range(0, 24) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      r   = ($urandom_range(0, 1499) == 0);
      drive(pv, rdy, r);
    end
    drain(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
